ls_unit: RTL and testbench
==========================

Name: ls_unit

Overview:
- Load/store execution unit, directly downstream of the load/store buffer.
- Accepts one memory op at a time from the buffer and drives a single request to the memory controller (which performs byte assembly).
- On load completion, formats the data (sign/zero extension) and broadcasts it on the LS-unit CDB.
- Raises busy while an op is outstanding, so the buffer holds its head entry.

Parameters:
- ROB_W, 4, width of ROB id; id 0 = ZERO_ROB (no producer).
- OP_W, 6, width of openum field; encodings are OPENUM_LB/LH/LW/LBU/LHU/SB/SH/SW from constant.v.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset: state cleared on a clk edge when rst==0
- rdy  in  1  global ready; when low, all state and outputs hold
- enable_signal_from_lsb  in  1  op valid this cycle
- openum_from_lsb  in  OP_W  memory op
- mem_address_from_lsb  in  32  effective address
- stored_data_from_lsb  in  32  store data (low bytes used)
- rob_id_from_lsb  in  ROB_W  ROB id of op
- busy_signal_to_lsb  out  1  unit occupied
- mem_req_valid  out  1  request to memory controller (level, held until done)
- mem_req_wr  out  1  1=store, 0=load
- mem_req_addr  out  32  request address
- mem_req_data  out  32  store data
- mem_req_size  out  3  byte count: 1, 2 or 4
- mem_done  in  1  one-cycle completion pulse from controller
- mem_rdata  in  32  load data, bytes in low lanes, valid with mem_done
- misbranch_flag  in  1  pipeline flush
- valid_signal_to_cdb  out  1  one-cycle result broadcast
- rob_id_to_cdb  out  ROB_W  producer id
- result_to_cdb  out  32  formatted result

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE.
  - busy, mem_req_valid, mem_req_wr, valid_signal_to_cdb = 0.
  - mem_req_addr, mem_req_data, result_to_cdb = 0; mem_req_size = 0; rob_id_to_cdb = ZERO_ROB.
  - Reset mid-request abandons the op; no CDB output.
- rdy==0: no state change; mem_done/enable arriving in that cycle are ignored (controller and buffer also stall on rdy).
- States: IDLE, WAIT_MEM, ABORT.
- IDLE:
  - enable=1 and misbranch=0: latch op, address, data and rob id.
  - Next edge: mem_req_valid=1, busy=1, state=WAIT_MEM (request visible 1 cycle after accept).
  - Size decode: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW=4; mem_req_wr=1 for SB/SH/SW.
  - enable while busy=1 is a protocol error and is ignored.
- WAIT_MEM:
  - Hold all request outputs stable until mem_done.
  - On mem_done: mem_req_valid=0, busy=0, state=IDLE.
  - Load: next edge sets valid_signal_to_cdb=1 for exactly one cycle, with rob_id_to_cdb = latched id.
    - LB: sign-extend [7:0]; LBU: zero-extend [7:0]; LH: sign-extend [15:0]; LHU: zero-extend [15:0]; LW: full word.
  - Load-to-use latency = mem_done edge + 1.
  - Store: no CDB unless the optional feature is enabled.
- Misbranch:
  - misbranch in IDLE: enable in the same cycle is dropped.
  - misbranch during WAIT_MEM with a load: go to ABORT. Request stays asserted until mem_done (controller cannot cancel), then IDLE with no CDB output; busy stays 1 through ABORT.
  - misbranch during a store: ignored; a committed store always completes.
  - misbranch coinciding with mem_done of a load: broadcast suppressed.
- New accept: the earliest accept is the cycle after busy falls (busy output low). Back-to-back ops are therefore spaced by at least 1 idle cycle.
- valid_signal_to_cdb is never high for two consecutive cycles; it is 0 whenever no completion occurred in the previous cycle.

Optional Feature:
- LSU_STORE_ACK_EN defined: store completion broadcasts on the CDB, with valid=1 for one cycle at mem_done+1, rob_id = store id, result=0. This lets the ROB retire stores on completion. misbranch never suppresses this ack.
- Undefined: stores never drive the CDB; valid_signal_to_cdb relates to loads only.

Test Plan:
- LB at 0x100, mem_rdata=0x000000F0, done 3 cycles after request -> single CDB pulse, result 0xFFFFFFF0, rob id 5, at done+1; busy low after done.
- LHU at 0x200 with mem_rdata=0x0000ABCD -> result 0x0000ABCD; LH same data -> 0xFFFFABCD.
- SH addr 0x300, data 0x12345678 -> mem_req_wr=1, size=2, data 0x12345678 held until done. No CDB without LSU_STORE_ACK_EN; with it, one pulse, result 0.
- LW issued, misbranch 1 cycle later, done 4 cycles later -> busy stays 1 until done, no CDB pulse, then a new LW is accepted and returns correctly.
- rdy held low for 3 cycles in WAIT_MEM, with a spurious done ignored -> outputs frozen; the real done after rdy returns completes normally.
- Drive rst=0 during WAIT_MEM -> next edge all outputs 0; a later mem_done produces no CDB pulse.

Source files
------------

// File: rtl/ls_unit_if.sv
// Bundles the LSB-side, memory-controller and CDB signals of the load/store unit.
// master = the ls_unit itself, slave = the surrounding pipeline/controller.
// No storage; pure wiring with direction modports.
interface ls_unit_if #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
);
  logic             enable_signal_from_lsb;
  logic [OP_W-1:0]  openum_from_lsb;
  logic [31:0]      mem_address_from_lsb;
  logic [31:0]      stored_data_from_lsb;
  logic [ROB_W-1:0] rob_id_from_lsb;
  logic             busy_signal_to_lsb;

  logic             mem_req_valid;
  logic             mem_req_wr;
  logic [31:0]      mem_req_addr;
  logic [31:0]      mem_req_data;
  logic [2:0]       mem_req_size;
  logic             mem_done;
  logic [31:0]      mem_rdata;

  logic             misbranch_flag;
  logic             valid_signal_to_cdb;
  logic [ROB_W-1:0] rob_id_to_cdb;
  logic [31:0]      result_to_cdb;

  modport master (
    input  enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
           stored_data_from_lsb, rob_id_from_lsb, mem_done, mem_rdata, misbranch_flag,
    output busy_signal_to_lsb, mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
           mem_req_size, valid_signal_to_cdb, rob_id_to_cdb, result_to_cdb
  );

  modport slave (
    output enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
           stored_data_from_lsb, rob_id_from_lsb, mem_done, mem_rdata, misbranch_flag,
    input  busy_signal_to_lsb, mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
           mem_req_size, valid_signal_to_cdb, rob_id_to_cdb, result_to_cdb
  );
endinterface

// File: rtl/ls_unit.sv
// Load/store unit: one op at a time to the memory controller, loads formatted onto the CDB.
// Latency: request 1 cycle after accept; CDB result 1 cycle after mem_done.
// Backpressure: busy holds the LSB head; rdy low freezes everything. Option: LSU_STORE_ACK_EN.
module ls_unit #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  ls_unit_if.master bus
);

  localparam logic [OP_W-1:0] OPENUM_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OPENUM_LH  = OP_W'(2);
  localparam logic [OP_W-1:0] OPENUM_LW  = OP_W'(3);
  localparam logic [OP_W-1:0] OPENUM_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OPENUM_LHU = OP_W'(5);
  localparam logic [OP_W-1:0] OPENUM_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OPENUM_SH  = OP_W'(7);
  localparam logic [OP_W-1:0] OPENUM_SW  = OP_W'(8);
  localparam logic [ROB_W-1:0] ZERO_ROB  = '0;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, ABORT} state_t;

  state_t           state_q, state_n;
  logic             busy_q, busy_n;
  logic             req_vld_q, req_vld_n;
  logic             req_wr_q, req_wr_n;
  logic [31:0]      req_addr_q, req_addr_n;
  logic [31:0]      req_data_q, req_data_n;
  logic [2:0]       req_size_q, req_size_n;
  logic [OP_W-1:0]  op_q, op_n;
  logic [ROB_W-1:0] rob_q, rob_n;
  logic             cdb_vld_q, cdb_vld_n;
  logic [ROB_W-1:0] cdb_rob_q, cdb_rob_n;
  logic [31:0]      cdb_res_q, cdb_res_n;

  logic [2:0]       dec_size;
  logic             dec_wr;
  logic [31:0]      load_fmt;

  always_comb begin
    dec_size = 3'd4;
    dec_wr   = 1'b0;
    case (bus.openum_from_lsb)
      OPENUM_LB, OPENUM_LBU: dec_size = 3'd1;
      OPENUM_LH, OPENUM_LHU: dec_size = 3'd2;
      OPENUM_SB: begin dec_size = 3'd1; dec_wr = 1'b1; end
      OPENUM_SH: begin dec_size = 3'd2; dec_wr = 1'b1; end
      OPENUM_SW: begin dec_size = 3'd4; dec_wr = 1'b1; end
      default:   dec_size = 3'd4;
    endcase
  end

  // Controller returns bytes in the low lanes; only extension is left to do here.
  always_comb begin
    load_fmt = bus.mem_rdata;
    case (op_q)
      OPENUM_LB:  load_fmt = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      OPENUM_LBU: load_fmt = {24'd0, bus.mem_rdata[7:0]};
      OPENUM_LH:  load_fmt = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      OPENUM_LHU: load_fmt = {16'd0, bus.mem_rdata[15:0]};
      default:    load_fmt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_n    = state_q;
    busy_n     = busy_q;
    req_vld_n  = req_vld_q;
    req_wr_n   = req_wr_q;
    req_addr_n = req_addr_q;
    req_data_n = req_data_q;
    req_size_n = req_size_q;
    op_n       = op_q;
    rob_n      = rob_q;
    cdb_vld_n  = 1'b0;
    cdb_rob_n  = cdb_rob_q;
    cdb_res_n  = cdb_res_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_signal_from_lsb && !bus.misbranch_flag) begin
          state_n    = WAIT_MEM;
          busy_n     = 1'b1;
          req_vld_n  = 1'b1;
          req_wr_n   = dec_wr;
          req_addr_n = bus.mem_address_from_lsb;
          req_data_n = bus.stored_data_from_lsb;
          req_size_n = dec_size;
          op_n       = bus.openum_from_lsb;
          rob_n      = bus.rob_id_from_lsb;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_done) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          req_vld_n = 1'b0;
          if (!req_wr_q && !bus.misbranch_flag) begin
            cdb_vld_n = 1'b1;
            cdb_rob_n = rob_q;
            cdb_res_n = load_fmt;
          end
`ifdef LSU_STORE_ACK_EN
          else if (req_wr_q) begin
            cdb_vld_n = 1'b1;
            cdb_rob_n = rob_q;
            cdb_res_n = 32'd0;
          end
`endif
        end else if (bus.misbranch_flag && !req_wr_q) begin
          // The controller cannot cancel, so the request rides out to mem_done.
          state_n = ABORT;
        end
      end
      ABORT: begin
        if (bus.mem_done) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          req_vld_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      req_vld_q  <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= 32'd0;
      req_data_q <= 32'd0;
      req_size_q <= 3'd0;
      op_q       <= '0;
      rob_q      <= ZERO_ROB;
      cdb_vld_q  <= 1'b0;
      cdb_rob_q  <= ZERO_ROB;
      cdb_res_q  <= 32'd0;
    end else if (rdy) begin
      state_q    <= state_n;
      busy_q     <= busy_n;
      req_vld_q  <= req_vld_n;
      req_wr_q   <= req_wr_n;
      req_addr_q <= req_addr_n;
      req_data_q <= req_data_n;
      req_size_q <= req_size_n;
      op_q       <= op_n;
      rob_q      <= rob_n;
      cdb_vld_q  <= cdb_vld_n;
      cdb_rob_q  <= cdb_rob_n;
      cdb_res_q  <= cdb_res_n;
    end
  end

  assign bus.busy_signal_to_lsb  = busy_q;
  assign bus.mem_req_valid       = req_vld_q;
  assign bus.mem_req_wr          = req_wr_q;
  assign bus.mem_req_addr        = req_addr_q;
  assign bus.mem_req_data        = req_data_q;
  assign bus.mem_req_size        = req_size_q;
  assign bus.valid_signal_to_cdb = cdb_vld_q;
  assign bus.rob_id_to_cdb       = cdb_rob_q;
  assign bus.result_to_cdb       = cdb_res_q;

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: the bench plays LSB and memory controller; CDB results go through a
// scoreboard queue checked by an independent monitor.
module tb_ls_unit;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  ls_unit_if #(.ROB_W(4), .OP_W(6)) bus();

  ls_unit #(.ROB_W(4), .OP_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] r);
    int b;
    int h;
    b = int'(r & 32'hFF);
    h = int'(r & 32'hFFFF);
    case (op)
      OP_LB:   return (b >= 128) ? 32'(b - 256) : 32'(b);
      OP_LBU:  return 32'(b);
      OP_LH:   return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      OP_LHU:  return 32'(h);
      default: return r;
    endcase
  endfunction

  function automatic int model_size(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit model_wr(input logic [5:0] op);
    return (op == OP_SB || op == OP_SH || op == OP_SW);
  endfunction

  // Monitor: every CDB pulse must match the oldest outstanding expectation, in value and cycle.
  always @(negedge clk) begin
    if (bus.valid_signal_to_cdb === 1'b1) begin
      if (sb.size() == 0) begin
        chk("cdb_spurious", 32'(bus.valid_signal_to_cdb), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("cdb_rob", 32'(bus.rob_id_to_cdb), 32'(mon_e.rob));
        chk("cdb_result", bus.result_to_cdb, mon_e.res);
        chk("cdb_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_signal_to_lsb !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("busy_timeout", 32'(bus.busy_signal_to_lsb), 32'd0);
  endtask

  // delay: cycles the request is visible before the mem_done cycle.
  // misb_at: cycle index (0..delay) with misbranch high, -1 for none.
  task automatic issue_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input logic [3:0] rob, input int delay,
                          input int misb_at, input bit stall);
    bit flushed;
    bit wr;
    wr = model_wr(op);
    wait_idle();
    bus.enable_signal_from_lsb = 1'b1;
    bus.openum_from_lsb        = op;
    bus.mem_address_from_lsb   = addr;
    bus.stored_data_from_lsb   = data;
    bus.rob_id_from_lsb        = rob;
    tick();
    bus.enable_signal_from_lsb = 1'b0;
    bus.mem_address_from_lsb   = $urandom;
    bus.stored_data_from_lsb   = $urandom;
    bus.rob_id_from_lsb        = 4'($urandom);
    chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("busy_set", 32'(bus.busy_signal_to_lsb), 32'd1);
    chk("req_wr", 32'(bus.mem_req_wr), 32'(wr));
    chk("req_size", 32'(bus.mem_req_size), 32'(model_size(op)));
    chk("req_addr", bus.mem_req_addr, addr);
    if (wr) chk("req_data", bus.mem_req_data, data);
    if (stall) begin
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (i == 1) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = ~rdata;
        end
        tick();
        bus.mem_done = 1'b0;
        chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("stall_busy", 32'(bus.busy_signal_to_lsb), 32'd1);
        chk("stall_addr", bus.mem_req_addr, addr);
      end
      rdy = 1'b1;
    end
    flushed = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (i == misb_at) begin
        bus.misbranch_flag = 1'b1;
        flushed = 1'b1;
      end
      tick();
      bus.misbranch_flag = 1'b0;
      chk("req_held", 32'(bus.mem_req_valid), 32'd1);
      chk("busy_held", 32'(bus.busy_signal_to_lsb), 32'd1);
      chk("addr_held", bus.mem_req_addr, addr);
      if (wr) chk("data_held", bus.mem_req_data, data);
    end
    if (misb_at == delay) begin
      bus.misbranch_flag = 1'b1;
      flushed = 1'b1;
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    if (!wr && !flushed) sb.push_back('{rob, model_load(op, rdata), cyc + 1});
`ifdef LSU_STORE_ACK_EN
    if (wr) sb.push_back('{rob, 32'd0, cyc + 1});
`endif
    tick();
    bus.mem_done       = 1'b0;
    bus.misbranch_flag = 1'b0;
    bus.mem_rdata      = $urandom;
    chk("busy_clear", 32'(bus.busy_signal_to_lsb), 32'd0);
    chk("req_clear", 32'(bus.mem_req_valid), 32'd0);
  endtask

  logic [5:0] ops[8];

  initial begin
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    bus.enable_signal_from_lsb = 1'b0;
    bus.openum_from_lsb        = '0;
    bus.mem_address_from_lsb   = '0;
    bus.stored_data_from_lsb   = '0;
    bus.rob_id_from_lsb        = '0;
    bus.mem_done               = 1'b0;
    bus.mem_rdata              = '0;
    bus.misbranch_flag         = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_size", 32'(bus.mem_req_size), 32'd0);
    chk("rst_cdb_valid", 32'(bus.valid_signal_to_cdb), 32'd0);
    chk("rst_cdb_rob", 32'(bus.rob_id_to_cdb), 32'd0);
    rst = 1'b1;
    tick();

    issue_op(OP_LB, 32'h100, 32'h0, 32'h000000F0, 4'd5, 3, -1, 1'b0);
    issue_op(OP_LHU, 32'h200, 32'h0, 32'h0000ABCD, 4'd6, 2, -1, 1'b0);
    issue_op(OP_LH, 32'h200, 32'h0, 32'h0000ABCD, 4'd7, 2, -1, 1'b0);
    issue_op(OP_SH, 32'h300, 32'h12345678, 32'h0, 4'd8, 2, -1, 1'b0);
    issue_op(OP_LW, 32'h400, 32'h0, 32'hCAFEF00D, 4'd9, 4, 1, 1'b0);
    issue_op(OP_LW, 32'h404, 32'h0, 32'h89ABCDEF, 4'd10, 1, -1, 1'b0);
    issue_op(OP_LW, 32'h408, 32'h0, 32'h13579BDF, 4'd11, 1, -1, 1'b1);
    issue_op(OP_SW, 32'h40C, 32'hDEADBEEF, 32'h0, 4'd12, 2, 0, 1'b0);
    issue_op(OP_LBU, 32'h410, 32'h0, 32'h000000F0, 4'd13, 0, 0, 1'b0);

    // Flush in IDLE drops a same-cycle enable.
    wait_idle();
    bus.enable_signal_from_lsb = 1'b1;
    bus.misbranch_flag         = 1'b1;
    bus.openum_from_lsb        = OP_LW;
    tick();
    bus.enable_signal_from_lsb = 1'b0;
    bus.misbranch_flag         = 1'b0;
    chk("flush_drop_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
    chk("flush_drop_req", 32'(bus.mem_req_valid), 32'd0);

    // Reset while a request is outstanding abandons it.
    bus.enable_signal_from_lsb = 1'b1;
    bus.openum_from_lsb        = OP_LW;
    bus.mem_address_from_lsb   = 32'h500;
    bus.rob_id_from_lsb        = 4'd3;
    tick();
    bus.enable_signal_from_lsb = 1'b0;
    chk("pre_rst_req", 32'(bus.mem_req_valid), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
    chk("midrst_req", 32'(bus.mem_req_valid), 32'd0);
    chk("midrst_addr", bus.mem_req_addr, 32'd0);
    chk("midrst_size", 32'(bus.mem_req_size), 32'd0);
    chk("midrst_result", bus.result_to_cdb, 32'd0);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    tick();
    bus.mem_done = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy_signal_to_lsb), 32'd0);

    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      int d;
      int m;
      op = ops[$urandom_range(0, 7)];
      d  = $urandom_range(0, 5);
      m  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d) : -1;
      issue_op(op, $urandom, $urandom, $urandom, 4'($urandom_range(1, 15)), d, m,
               $urandom_range(0, 15) == 0);
    end

    repeat (5) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
